fp_sub_result_fixup: RTL
========================

// Module: fp_sub_result_fixup
// PURPOSE
//  Consumer side of the mantissa inversion controls in the Add_Sub path. It takes the raw
//  adder output (A + conditionally inverted B + cin=1) and removes the inversion effect:
//  drops the subtraction carry, resolves the result sign, and normalizes via LZC/shift with
//  exponent adjust. 2-stage valid/ready pipeline; feeds the rounding stage.
// PARAMETERS
//  MW  23  fraction width (hidden bit excluded)
//  EW  8   exponent width
//  GW  3   guard/round/sticky bits below fraction; SUM_W = MW+GW+2 (carry+hidden+frac+GRS)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       async active-low reset
//  in_valid      in   1       input beat valid
//  in_ready      out  1       block can accept a beat
//  in_sum        in   SUM_W   raw adder result, bit SUM_W-1 = carry-out
//  in_exp        in   EW      larger operand exponent
//  in_eff_sub    in   1       effective operation: 0 add, 1 subtract
//  in_sign_a     in   1       sign of operand A
//  in_sign_b     in   1       sign of operand B
//  in_sign_d     in   1       sign of d=ExpA-ExpB (1: B larger)
//  in_zero_d     in   1       d==0
//  in_cmp        in   2       [0]: aligned-path (B) mantissa less; [1]: A mantissa less
//  out_valid     out  1       result valid
//  out_ready     in   1       downstream accepts
//  out_sign      out  1       result sign
//  out_exp       out  EW      adjusted exponent
//  out_mant      out  MW+GW+1 normalized significand, hidden bit at MSB
//  out_zero      out  1       exact zero result
//  out_ovf       out  1       exponent reached all-ones on carry renormalize
//  out_uflow     out  1       result denormal (exp forced 0)
//  out_err       out  1       sticky invariant error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: s1/s2 valid=0; all out_* = 0; in_ready=1 after reset release.
//  - Handshake: beat moves on valid&ready; stage loads when empty or its successor advances.
//    in_ready = !s1_v | (s1->s2 advance). Throughput 1/cycle, latency 2 cycles unstalled.
//    Stalled outputs hold stable; no beat dropped or duplicated. Reset mid-stall flushes all.
//  - S1: sub: discard carry, mag=in_sum[SUM_W-2:0]. add & carry: mag={carry,sum[..:1]},
//    LSB ORed into sticky bit0, exp+1; ovf=1 if exp+1 == all-ones.
//    Sign: !zero_d -> sign_d?sign_b:sign_a; zero_d -> cmp[0]?sign_a : cmp[1]?sign_b : sign_a.
//    Zero: eff_sub & mag==0 -> zero=1, sign=0 (cmp==00 with zero_d must give mag 0).
//    LZC over mag (MW+GW+1 bits), registered.
//  - S2: lzc<exp -> mant=mag<<lzc, exp-=lzc. lzc>=exp & exp>0 -> mant=mag<<(exp-1),
//    exp=0, uflow=1. exp==0 input -> no shift, uflow=1. zero -> mant=0, exp=0.
//  - Exponent arithmetic in EW+1 bits; no wrap-around permitted.
// CONFIGURATION
//  FP_FIXUP_INVARIANT_CHECK_EN defined: out_err sets when an accepted beat has eff_sub=1 and
//  carry-out=0 (smaller operand was not the inverted one); sticky until reset.
//  Undefined: out_err tied 0, no check logic.
// STRUCTURE
//  Shared package fpu_pkg: MW/EW/GW defaults, SUM_W/MAG_W derived constants, cmp bit
//  index constants. One sub-module: fp_lzc (combinational leading-zero count, width param).
// TESTING (MW=23, GW=3, EW=8, SUM_W=28)
//  1 add carry: sum=28'h8000000, exp=127, eff_sub=0 -> 2 cyc: exp=128, mant=27'h4000000
//  2 cancel: eff_sub=1, sum=28'h8000008, exp=100 -> lzc=23, exp=77, mant=27'h4000000
//  3 exact zero: eff_sub=1, zero_d=1, cmp=00, sum=28'h8000000 -> zero=1, sign=0, exp=0
//  4 underflow: as 2 with exp=10 -> mant=27'h0001000, exp=0, uflow=1
//  5 backpressure: 3 back-to-back beats, out_ready=0 4 cyc -> in_ready drops, order kept
//  6 macro on: eff_sub=1, sum=28'h4000000 -> out_err=1 sticky; macro off -> out_err=0

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the FP add/sub result fixup path.
//   MW/EW/GW : fraction, exponent and guard/round/sticky widths
//   SUM_W    : raw adder width (carry + hidden + fraction + GRS)
//   MAG_W    : magnitude width after the carry is resolved
//   LZ_W     : width of a leading-zero count over MAG_W bits
//   CMP_*    : bit positions inside the in_cmp mantissa-compare vector
package fpu_pkg;
  localparam int MW    = 23;
  localparam int EW    = 8;
  localparam int GW    = 3;
  localparam int SUM_W = MW + GW + 2;
  localparam int MAG_W = MW + GW + 1;
  localparam int LZ_W  = $clog2(MAG_W + 1);

  localparam int CMP_B_LESS = 0;  // aligned-path (B) mantissa smaller
  localparam int CMP_A_LESS = 1;  // A mantissa smaller
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   vec : input vector, MSB first
//   cnt : number of zeros above the highest set bit (W when vec is all zero)
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);
  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (vec[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_sub_result_fixup.sv
// Post-adder fixup for the add/sub path: removes the effect of the B-mantissa
// inversion, resolves the result sign, detects exact zero and normalizes the
// magnitude (LZC + left shift) with exponent adjust. Two-stage valid/ready
// pipeline feeding the rounding stage.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_sum                raw adder result, MSB = carry-out
//   in_exp                larger operand exponent
//   in_eff_sub            effective subtract
//   in_sign_a/b/d, in_zero_d, in_cmp   sign resolution inputs
//   out_valid/out_ready   output handshake
//   out_sign/exp/mant     normalized result, hidden bit at out_mant MSB
//   out_zero/ovf/uflow    exact zero, exponent hit all-ones, denormal
//   out_err               sticky invariant error
// Optional: FP_FIXUP_INVARIANT_CHECK_EN enables the out_err check
// (effective subtract without carry-out); otherwise out_err is tied low.
module fp_sub_result_fixup
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic [EW-1:0]      in_exp,
  input  logic               in_eff_sub,
  input  logic               in_sign_a,
  input  logic               in_sign_b,
  input  logic               in_sign_d,
  input  logic               in_zero_d,
  input  logic [1:0]         in_cmp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EW-1:0]      out_exp,
  output logic [MAG_W-1:0]   out_mant,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               out_uflow,
  output logic               out_err
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic s1_adv, s2_adv, in_fire, carry;

  assign s2_adv    = !vld_pipe[2] | out_ready;
  assign s1_adv    = vld_pipe[1] & s2_adv;
  assign in_ready  = !vld_pipe[1] | s1_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[2];
  assign carry     = in_sum[SUM_W-1];

  // ---------------- stage 1: carry / sign / zero / LZC ----------------
  logic [MAG_W-1:0] mag_nx;
  logic [EW:0]      exp1_nx;
  logic             ovf1_nx, sign1_nx, zero1_nx;
  logic [LZ_W-1:0]  lzc_nx;

  always_comb begin
    // Subtract: carry-out is the artefact of the inverted operand, drop it.
    mag_nx  = in_sum[MAG_W-1:0];
    exp1_nx = {1'b0, in_exp};
    ovf1_nx = 1'b0;
    if (!in_eff_sub && carry) begin
      // Add overflowed into the carry: shift right one, keep the lost LSB sticky.
      mag_nx  = {1'b1, in_sum[MAG_W-1:2], in_sum[1] | in_sum[0]};
      exp1_nx = {1'b0, in_exp} + (EW+1)'(1);
      ovf1_nx = (exp1_nx == {1'b0, {EW{1'b1}}});
    end

    if (!in_zero_d)                 sign1_nx = in_sign_d ? in_sign_b : in_sign_a;
    else if (in_cmp[CMP_B_LESS])    sign1_nx = in_sign_a;
    else if (in_cmp[CMP_A_LESS])    sign1_nx = in_sign_b;
    else                            sign1_nx = in_sign_a;

    zero1_nx = in_eff_sub && (mag_nx == '0);
    if (zero1_nx) sign1_nx = 1'b0;
  end

  fp_lzc #(.W(MAG_W), .CW(LZ_W)) u_lzc (.vec(mag_nx), .cnt(lzc_nx));

  logic [MAG_W-1:0] s1_mag;
  logic [EW:0]      s1_exp;
  logic [LZ_W-1:0]  s1_lzc;
  logic             s1_sign, s1_zero, s1_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_mag      <= '0;
      s1_exp      <= '0;
      s1_lzc      <= '0;
      s1_sign     <= 1'b0;
      s1_zero     <= 1'b0;
      s1_ovf      <= 1'b0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (in_fire) begin
        s1_mag  <= mag_nx;
        s1_exp  <= exp1_nx;
        s1_lzc  <= lzc_nx;
        s1_sign <= sign1_nx;
        s1_zero <= zero1_nx;
        s1_ovf  <= ovf1_nx;
      end
    end
  end

  // ---------------- stage 2: normalize ----------------
  logic [EW:0]      lz_ext, exp2_nx;
  logic [MAG_W-1:0] mant2_nx;
  logic             uflow2_nx;

  assign lz_ext = (EW+1)'(s1_lzc);

  always_comb begin
    mant2_nx  = s1_mag << lz_ext;
    exp2_nx   = s1_exp - lz_ext;
    uflow2_nx = 1'b0;
    if (s1_zero) begin
      mant2_nx = '0;
      exp2_nx  = '0;
    end else if (s1_exp == '0) begin
      // Already denormal: nothing to shift into.
      mant2_nx  = s1_mag;
      exp2_nx   = '0;
      uflow2_nx = 1'b1;
    end else if (lz_ext >= s1_exp) begin
      // Full normalization would go below exponent 1: stop at the denormal boundary.
      mant2_nx  = s1_mag << (s1_exp - (EW+1)'(1));
      exp2_nx   = '0;
      uflow2_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_uflow   <= 1'b0;
    end else begin
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv) begin
        out_sign  <= s1_sign;
        out_exp   <= exp2_nx[EW-1:0];
        out_mant  <= mant2_nx;
        out_zero  <= s1_zero;
        out_ovf   <= s1_ovf;
        out_uflow <= uflow2_nx;
      end
    end
  end

`ifdef FP_FIXUP_INVARIANT_CHECK_EN
  // A subtract must always carry out when the smaller operand was the inverted one.
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= 1'b0;
    else if (in_fire && in_eff_sub && !carry) err_q <= 1'b1;
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif
endmodule
